// File: rtl/bnn_pkg.sv
// Shared definitions for the MNIST BNN pipeline: top FSM state codes, image size and loader FSM states.
// LOADER_CHECKSUM_EN adds the loader CHECK state.
package bnn_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_L1   = 3'd2;
    localparam logic [2:0] ST_L2   = 3'd3;
    localparam logic [2:0] ST_L3   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam int NUM_PIXELS = 784;
    localparam int BYTE_W     = 8;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_FULL  = 2'd2,
        LD_CHECK = 2'd3
    } loader_state_e;
`else
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_FILL = 2'd1,
        LD_FULL = 2'd2
    } loader_state_e;
`endif

endpackage

// File: rtl/bnn_pixel_loader.sv
// Packs byte-wide binarized pixel beats into the 784-bit image for layer one.
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum beat validates each frame.
module bnn_pixel_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int BYTE_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            state,
    input  logic [BYTE_W-1:0]     byte_in,
    input  logic                  byte_valid,
    input  logic                  frame_start,
    output logic [NUM_PIXELS-1:0] pixels,
    output logic                  load_done,
    output logic [6:0]            byte_count,
    output logic                  overrun_err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic                  checksum_err
`endif
);
    import bnn_pkg::*;

    localparam int         NUM_BYTES = NUM_PIXELS / BYTE_W;
    localparam int         PIX_IDX_W = $clog2(NUM_PIXELS);
    localparam logic [6:0] LAST_BEAT = 7'(NUM_BYTES - 1);

    loader_state_e          ld_q, ld_d;
    logic [NUM_PIXELS-1:0]  pixels_q, pixels_d;
    logic [6:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   ovr_q, ovr_d;
    logic [PIX_IDX_W-1:0]   wr_base_s;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]      csum_q, csum_d;
    logic                   cerr_q, cerr_d;
`endif

    // State, image, counter and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_q     <= LD_IDLE;
            pixels_q <= '0;
            cnt_q    <= 7'd0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
            cerr_q   <= 1'b0;
`endif
        end else begin
            ld_q     <= ld_d;
            pixels_q <= pixels_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
            cerr_q   <= cerr_d;
`endif
        end
    end

    // Loader next-state: leaving LOAD beats frame_start, which beats the overrun check
    always_comb begin
        ld_d      = ld_q;
        pixels_d  = pixels_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        cerr_d    = cerr_q;
`endif
        wr_base_s = PIX_IDX_W'(cnt_q) * PIX_IDX_W'(BYTE_W);

        case (ld_q)
            LD_IDLE: begin
                cnt_d  = 7'd0;
                done_d = 1'b0;
                if (state == ST_LOAD) begin
                    ld_d = LD_FILL;
                end else begin
                    ld_d = LD_IDLE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LD_FILL, LD_FULL, LD_CHECK: begin
`else
            LD_FILL, LD_FULL: begin
`endif
                if (state != ST_LOAD) begin
                    ld_d   = LD_IDLE;
                    done_d = 1'b0;
                    cnt_d  = 7'd0;
                end else if (byte_valid && frame_start) begin
                    // Resync: old bits above beat 0 stay until overwritten
                    pixels_d[BYTE_W-1:0] = byte_in;
                    cnt_d  = 7'd1;
                    done_d = 1'b0;
                    ovr_d  = 1'b0;
                    ld_d   = LD_FILL;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = byte_in;
                    cerr_d = 1'b0;
`endif
                end else if (byte_valid) begin
                    case (ld_q)
                        LD_FILL: begin
                            pixels_d[wr_base_s +: BYTE_W] = byte_in;
                            cnt_d = cnt_q + 7'd1;
`ifdef LOADER_CHECKSUM_EN
                            csum_d = csum_q ^ byte_in;
                            if (cnt_q == LAST_BEAT) begin
                                ld_d = LD_CHECK;
                            end else begin
                                ld_d = LD_FILL;
                            end
`else
                            if (cnt_q == LAST_BEAT) begin
                                ld_d   = LD_FULL;
                                done_d = 1'b1;
                            end else begin
                                ld_d = LD_FILL;
                            end
`endif
                        end
                        LD_FULL: begin
                            ovr_d = 1'b1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        LD_CHECK: begin
                            if (byte_in == csum_q) begin
                                ld_d   = LD_FULL;
                                done_d = 1'b1;
                            end else begin
                                // Bad checksum: wait for the whole frame again
                                ld_d   = LD_FILL;
                                cerr_d = 1'b1;
                                cnt_d  = 7'd0;
                                csum_d = '0;
                            end
                        end
`endif
                        default: begin
                            ld_d = LD_IDLE;
                        end
                    endcase
                end else begin
                    ld_d = ld_q;
                end
            end
            default: begin
                ld_d   = LD_IDLE;
                cnt_d  = 7'd0;
                done_d = 1'b0;
            end
        endcase
    end

    assign pixels      = pixels_q;
    assign load_done   = done_q;
    assign byte_count  = cnt_q;
    assign overrun_err = ovr_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum_err = cerr_q;
`endif

endmodule

// File: tb/tb_bnn_pixel_loader.sv
// Directed scoreboard bench for bnn_pixel_loader (optionally with LOADER_CHECKSUM_EN).
module tb_bnn_pixel_loader;
    import bnn_pkg::*;

    localparam int NB = NUM_PIXELS / BYTE_W;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            state;
    logic [BYTE_W-1:0]     byte_in;
    logic                  byte_valid;
    logic                  frame_start;
    logic [NUM_PIXELS-1:0] pixels;
    logic                  load_done;
    logic [6:0]            byte_count;
    logic                  overrun_err;
`ifdef LOADER_CHECKSUM_EN
    logic                  checksum_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [NUM_PIXELS-1:0] sb_q[$];
    logic [NUM_PIXELS-1:0] img;
    logic [BYTE_W-1:0]     run_xor;

    bnn_pixel_loader dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .pixels      (pixels),
        .load_done   (load_done),
        .byte_count  (byte_count),
        .overrun_err (overrun_err)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum_err(checksum_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NUM_PIXELS-1:0] obs,
                         input logic [NUM_PIXELS-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [BYTE_W-1:0] d, input logic fs);
        byte_in     = d;
        byte_valid  = 1'b1;
        frame_start = fs;
        @(posedge clk);
        #1;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        byte_in     = 8'h00;
    endtask

    // Drive one beat at index idx and update the bench's image/xor model
    task automatic put(input int idx, input logic [BYTE_W-1:0] d, input logic fs);
        if (fs) run_xor = 8'h00;
        img[idx*BYTE_W +: BYTE_W] = d;
        run_xor = run_xor ^ d;
        beat(d, fs);
    endtask

    task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
        beat(run_xor, 1'b0);
`endif
    endtask

    task automatic expect_frame(input string tag);
        logic [NUM_PIXELS-1:0] exp_img;
        int waited = 0;
        while (!load_done && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, "_done"}, {783'd0, load_done}, 784'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 784'd1, 784'd0);
        end else begin
            exp_img = sb_q.pop_front();
            check({tag, "_pixels"}, pixels, exp_img);
        end
    endtask

    initial begin
        reset       = 1'b1;
        state       = ST_IDLE;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        img         = '0;
        run_xor     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pixels", pixels, '0);
        check("rst_done", {783'd0, load_done}, 784'd0);
        check("rst_count", {777'd0, byte_count}, 784'd0);
        check("rst_ovr", {783'd0, overrun_err}, 784'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Beat during IDLE->FILL transition is ignored
        state = ST_LOAD;
        beat(8'hEE, 1'b1);
        check("idle_beat_count", {777'd0, byte_count}, 784'd0);
        check("idle_beat_pixels", pixels, '0);

        // Full frame of A5
        for (int k = 0; k < NB - 1; k++) put(k, 8'hA5, k == 0);
        check("f1_not_done", {783'd0, load_done}, 784'd0);
        check("f1_count97", {777'd0, byte_count}, 784'd97);
        put(NB - 1, 8'hA5, 1'b0);
        send_csum();
        sb_q.push_back(img);
        check("f1_done_lat1", {783'd0, load_done}, 784'd1);
        check("f1_count98", {777'd0, byte_count}, 784'd98);
        check("f1_ovr", {783'd0, overrun_err}, 784'd0);
        expect_frame("f1");

        // 99th beat overruns
        beat(8'hFF, 1'b0);
        check("ovr_set", {783'd0, overrun_err}, 784'd1);
        check("ovr_done_held", {783'd0, load_done}, 784'd1);
        check("ovr_pixels", pixels, img);
        check("ovr_count", {777'd0, byte_count}, 784'd98);

        // frame_start clears overrun and restarts the count
        put(0, 8'h3C, 1'b1);
        check("fs_ovr_clr", {783'd0, overrun_err}, 784'd0);
        check("fs_count1", {777'd0, byte_count}, 784'd1);
        check("fs_done_clr", {783'd0, load_done}, 784'd0);
        check("fs_old_bits", pixels, img);

        // Mid-frame resync after 40 beats
        for (int k = 1; k < 40; k++) put(k, 8'h5A, 1'b0);
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        check("fs_no_valid", {777'd0, byte_count}, 784'd40);
        put(0, 8'h3C, 1'b1);
        check("resync_count", {777'd0, byte_count}, 784'd1);
        check("resync_byte0", {776'd0, pixels[7:0]}, 784'h3C);
        check("resync_pixels", pixels, img);
        for (int k = 1; k < NB - 1; k++) put(k, 8'hC3, 1'b0);
        check("resync_not_done", {783'd0, load_done}, 784'd0);
        put(NB - 1, 8'hC3, 1'b0);
        send_csum();
        sb_q.push_back(img);
        expect_frame("resync");

        // Leave LOAD after 50 beats; beat in the leaving cycle is dropped
        for (int k = 0; k < 50; k++) put(k, 8'(k * 7 + 1), k == 0);
        check("l50_count", {777'd0, byte_count}, 784'd50);
        state = ST_L1;
        beat(8'hFF, 1'b0);
        check("leave_count", {777'd0, byte_count}, 784'd0);
        check("leave_done", {783'd0, load_done}, 784'd0);
        check("leave_low400", {384'd0, pixels[399:0]}, {384'd0, img[399:0]});
        check("leave_pixels", pixels, img);
        beat(8'hFF, 1'b1);
        beat(8'h0F, 1'b0);
        check("l1_pixels_held", pixels, img);
        check("l1_count", {777'd0, byte_count}, 784'd0);

        // Asynchronous reset mid-frame
        state = ST_LOAD;
        @(posedge clk);
        #1;
        for (int k = 0; k < 60; k++) put(k, 8'(k + 2), k == 0);
        check("r60_count", {777'd0, byte_count}, 784'd60);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pixels", pixels, '0);
        check("arst_count", {777'd0, byte_count}, 784'd0);
        check("arst_done", {783'd0, load_done}, 784'd0);
        check("arst_ovr", {783'd0, overrun_err}, 784'd0);
        img = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NB; k++) put(k, 8'(k) ^ 8'h55, k == 0);
        send_csum();
        sb_q.push_back(img);
        expect_frame("reload");
        check("reload_count", {777'd0, byte_count}, 784'd98);

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < NB; k++) put(k, 8'h01, k == 0);
        beat(8'h00, 1'b0);
        check("cs_ok_done", {783'd0, load_done}, 784'd1);
        check("cs_ok_err", {783'd0, checksum_err}, 784'd0);
        for (int k = 0; k < NB; k++) put(k, 8'h01, k == 0);
        beat(8'h01, 1'b0);
        check("cs_bad_err", {783'd0, checksum_err}, 784'd1);
        check("cs_bad_done", {783'd0, load_done}, 784'd0);
        check("cs_bad_count", {777'd0, byte_count}, 784'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bnn_pixel_loader.md
Name: bnn_pixel_loader

Overview:
- Byte-wide image loader that sits directly upstream of layer one in the MNIST BNN pipeline.
- Accepts 8 pixels per accepted beat from the input pins with a valid strobe, packs 98 beats into the 784-bit binarized image and holds it stable for the layers.
- Raises load_done for the top FSM.
- Only active while the top FSM reports the LOAD state.

Parameters:
- NUM_PIXELS, 784, image bits (28x28 binarized).
- BYTE_W, 8, pixels per accepted beat; NUM_PIXELS must be a multiple of BYTE_W.
- NUM_BYTES, NUM_PIXELS/BYTE_W (98), derived localparam, beats per frame.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- state, input, 3, top FSM state (encoding from the shared package).
- byte_in, input, BYTE_W, packed pixels; bit i is pixel (base+i).
- byte_valid, input, 1, byte_in is valid this cycle.
- frame_start, input, 1, marks byte_in as beat 0 of a frame.
- pixels, output, NUM_PIXELS, assembled image to layer one.
- load_done, output, 1, image complete (level).
- byte_count, output, 7, beats accepted in the current frame.
- overrun_err, output, 1, sticky: beat arrived after frame full.

Behaviour:
- Interface is fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- All flops clear on reset assertion: pixels=0, load_done=0, byte_count=0, overrun_err=0, FSM=IDLE.
- Reset asserted mid-frame discards the partial frame.
- Internal FSM states: IDLE, FILL, FULL.
- IDLE:
  - byte_count is held at 0.
  - Moves to FILL when state==ST_LOAD. Transition takes one cycle; a beat in that same cycle is ignored.
- FILL:
  - A beat is accepted on each cycle with byte_valid=1.
  - Accepted beat writes pixels[byte_count*BYTE_W +: BYTE_W] and increments byte_count.
  - On the NUM_BYTES-th accepted beat: go to FULL and register load_done=1. load_done is visible the cycle after that beat (latency 1).
- frame_start with byte_valid, in FILL or FULL:
  - Forces this beat to index 0; byte_count becomes 1.
  - load_done clears, overrun_err clears, FSM goes to FILL.
  - Bits of the previous image not yet overwritten keep their old values.
- frame_start without byte_valid: ignored.
- FULL:
  - load_done is held high.
  - byte_valid without frame_start: beat dropped, pixels unchanged, overrun_err<=1 (sticky).
- Leaving ST_LOAD:
  - If state!=ST_LOAD in FILL or FULL: go to IDLE, load_done<=0, byte_count<=0.
  - pixels is held unchanged so layers can compute.
  - overrun_err is kept.
- Outside ST_LOAD, byte_valid and frame_start are ignored entirely.
- Simultaneous events:
  - Leaving ST_LOAD has priority over an accepted beat in the same cycle; the beat is dropped.
  - frame_start has priority over the overrun check.
- Wrap-around: byte_count never exceeds NUM_BYTES; there is no wrap.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro:
  - A running XOR of all accepted beats is kept.
  - After beat NUM_BYTES, the FSM enters CHECK and requires one further beat: the checksum.
  - On match: load_done=1 on the next cycle.
  - On mismatch: checksum_err=1 (new output port, sticky, cleared by frame_start/reset). load_done stays 0 and the FSM returns to FILL with byte_count=0, awaiting a retransmit.
- Without the macro: no CHECK state, no checksum_err port; load_done follows beat NUM_BYTES as above.

Decomposition:
- Shared package bnn_pkg holds:
  - top FSM state constants ST_IDLE=3'd0, ST_LOAD=3'd1, ST_L1=3'd2, ST_L2=3'd3, ST_L3=3'd4, ST_DONE=3'd5;
  - NUM_PIXELS;
  - the loader FSM enum typedef.
- Shared with the top-level FSM and all layers.
- No sub-module is needed; the single module contains the FSM, counter and image register.

Test Plan:
- Reset, then state=ST_LOAD, 98 beats byte_in=8'hA5 with byte_valid=1 -> load_done=1 one cycle after beat 98; pixels = 98 copies of 8'hA5; byte_count=98; overrun_err=0.
- Full frame, then a 99th beat 8'hFF -> overrun_err=1, pixels unchanged, load_done stays 1; next frame_start beat clears overrun_err and gives byte_count=1.
- Mid-frame resync: 40 beats, then frame_start with 8'h3C -> pixels[7:0]=8'h3C, byte_count=1; load_done only after 97 more beats.
- State leaves ST_LOAD after 50 beats -> byte_count=0, load_done=0, pixels[399:0] retained; beats presented while state=ST_L1 leave pixels unchanged.
- Reset asserted at beat 60 -> all outputs 0 immediately (asynchronous); deasserting reset with state=ST_LOAD gives a clean reload of 98 beats.
- LOADER_CHECKSUM_EN: 98 beats 8'h01 plus checksum 8'h00 -> load_done=1; same frame with checksum 8'h01 -> checksum_err=1, load_done=0, byte_count=0.
